// File: rtl/wts_wave_reader_5ch_pkg.sv
// Shared widths, slot constants and pipeline payload types for the 5-channel wave reader.
package wts_wave_reader_5ch_pkg;

  localparam int unsigned CH_NUM     = 5;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned VOL_W      = 4;
  localparam int unsigned OUT_W      = 15;
  localparam int unsigned IDLE_SLOT  = 5;
  localparam int unsigned WADDR_W    = 7;
  localparam int unsigned RAM_ADDR_W = SLOT_W + WADDR_W;
  localparam int unsigned PROD_W     = SAMPLE_W + VOL_W;
  localparam int unsigned SEL_W      = VOL_W + 1;

  typedef struct packed {
    logic              vld;
    logic [SLOT_W-1:0] ch;
  } slot_t;

  // Sign-extend a channel product to accumulator width.
  function automatic logic [OUT_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(OUT_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/wts_wave_reader_5ch_if.sv
// Tone-generator, register, wave-RAM and mixed-output signals of the wave reader.
interface wts_wave_reader_5ch_if;
  import wts_wave_reader_5ch_pkg::*;

  logic [SLOT_W-1:0]     active;
  logic [WADDR_W-1:0]    wave_address;
  logic [VOL_W-1:0]      reg_volume_a;
  logic [VOL_W-1:0]      reg_volume_b;
  logic [VOL_W-1:0]      reg_volume_c;
  logic [VOL_W-1:0]      reg_volume_d;
  logic [VOL_W-1:0]      reg_volume_e;
  logic [CH_NUM-1:0]     reg_enable;
  logic [RAM_ADDR_W-1:0] ram_address;
  logic                  ram_rd;
  logic [SAMPLE_W-1:0]   ram_rdata;
  logic [OUT_W-1:0]      sound_out;
  logic                  sound_valid;

  modport master (
    output active, wave_address, reg_volume_a, reg_volume_b, reg_volume_c,
           reg_volume_d, reg_volume_e, reg_enable, ram_rdata,
    input  ram_address, ram_rd, sound_out, sound_valid
  );

  modport slave (
    input  active, wave_address, reg_volume_a, reg_volume_b, reg_volume_c,
           reg_volume_d, reg_volume_e, reg_enable, ram_rdata,
    output ram_address, ram_rd, sound_out, sound_valid
  );

endinterface

// File: rtl/wts_wave_reader_5ch_selector.sv
// Six-input mux selecting a per-channel field by slot index; slots 6..7 read as 0.
module wts_selector
  import wts_wave_reader_5ch_pkg::*;
#(
  parameter int unsigned WIDTH = SEL_W
) (
  input  logic [SLOT_W-1:0] sel_i,
  input  logic [WIDTH-1:0]  in0_i,
  input  logic [WIDTH-1:0]  in1_i,
  input  logic [WIDTH-1:0]  in2_i,
  input  logic [WIDTH-1:0]  in3_i,
  input  logic [WIDTH-1:0]  in4_i,
  input  logic [WIDTH-1:0]  in5_i,
  output logic [WIDTH-1:0]  out_o
);

  always_comb begin
    out_o = '0;
    case (sel_i)
      3'd0:    out_o = in0_i;
      3'd1:    out_o = in1_i;
      3'd2:    out_o = in2_i;
      3'd3:    out_o = in3_i;
      3'd4:    out_o = in4_i;
      3'd5:    out_o = in5_i;
      default: out_o = '0;
    endcase
  end

endmodule

// File: rtl/wts_wave_reader_5ch.sv
// Wave reader: issues wave-RAM reads per channel slot, scales samples by volume and
// mixes the five channels into one sample per round.
module wts_wave_reader_5ch
  import wts_wave_reader_5ch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  wts_wave_reader_5ch_if.slave  bus
);

  logic [RAM_ADDR_W-1:0] ram_address_q, ram_address_d;
  logic                  ram_rd_q, ram_rd_d;
  logic [SLOT_W-1:0]     k1_q, k1_d;
  slot_t                 s2_q, s2_d;
  logic [OUT_W-1:0]      acc_q, acc_d;
  logic [OUT_W-1:0]      sound_q, sound_d;
  logic                  sound_valid_q, sound_valid_d;
  logic                  armed_q, armed_d;

  logic [SEL_W-1:0]      sel_data;
  logic                  ch_en;
  logic [VOL_W-1:0]      ch_vol;
  logic [PROD_W-1:0]     prod_raw;
  logic [PROD_W-1:0]     product;
  logic [OUT_W-1:0]      product_ext;

  // Volume and enable are picked for the channel whose sample is returning now.
  wts_selector #(.WIDTH(SEL_W)) u_sel (
    .sel_i (s2_q.ch),
    .in0_i ({bus.reg_enable[0], bus.reg_volume_a}),
    .in1_i ({bus.reg_enable[1], bus.reg_volume_b}),
    .in2_i ({bus.reg_enable[2], bus.reg_volume_c}),
    .in3_i ({bus.reg_enable[3], bus.reg_volume_d}),
    .in4_i ({bus.reg_enable[4], bus.reg_volume_e}),
    .in5_i ('0),
    .out_o (sel_data)
  );

  assign ch_en       = sel_data[VOL_W];
  assign ch_vol      = sel_data[VOL_W-1:0];
  assign prod_raw    = {{VOL_W{bus.ram_rdata[SAMPLE_W-1]}}, bus.ram_rdata}
                     * {{SAMPLE_W{1'b0}}, ch_vol};
  assign product     = ch_en ? prod_raw : '0;
  assign product_ext = sext_prod(product);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_address_q <= '0;
      ram_rd_q      <= 1'b0;
      k1_q          <= '0;
      s2_q          <= '0;
      acc_q         <= '0;
      sound_q       <= '0;
      sound_valid_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      ram_address_q <= ram_address_d;
      ram_rd_q      <= ram_rd_d;
      k1_q          <= k1_d;
      s2_q          <= s2_d;
      acc_q         <= acc_d;
      sound_q       <= sound_d;
      sound_valid_q <= sound_valid_d;
      armed_q       <= armed_d;
    end
  end

  // Stage 1 issues the read; stage 2 scales and mixes. armed_q blocks output until a
  // channel-A load has happened since reset, so partial pre-reset rounds never emit.
  always_comb begin
    ram_address_d = ram_address_q;
    ram_rd_d      = 1'b0;
    k1_d          = k1_q;
    s2_d          = '{vld: ram_rd_q, ch: k1_q};
    acc_d         = acc_q;
    sound_d       = sound_q;
    sound_valid_d = 1'b0;
    armed_d       = armed_q;

    if (bus.active < SLOT_W'(IDLE_SLOT)) begin
      ram_address_d = {bus.active, bus.wave_address};
      ram_rd_d      = 1'b1;
      k1_d          = bus.active;
    end

    if (s2_q.vld) begin
      if (s2_q.ch == '0) begin
        acc_d   = product_ext;
        armed_d = 1'b1;
      end else begin
        acc_d = acc_q + product_ext;
      end
      if ((s2_q.ch == SLOT_W'(CH_NUM - 1)) && armed_q) begin
        sound_d       = acc_q + product_ext;
        sound_valid_d = 1'b1;
      end
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.sound_out   = sound_q;
  assign bus.sound_valid = sound_valid_q;

endmodule

// File: tb/tb_wts_wave_reader_5ch.sv
// Bench for wts_wave_reader_5ch: directed rounds against a slot-history mix model.
module tb_wts_wave_reader_5ch;

  logic clk;
  logic reset;
  wts_wave_reader_5ch_if wif ();

  wts_wave_reader_5ch dut (.clk(clk), .reset(reset), .bus(wif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram_mem [1024];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_sound = 0;
  int valid_cyc = 0;
  int a4_cyc = 0;
  bit rst_seen = 0;

  // Expected outputs for the current cycle, and the model's slot history.
  int exp_addr = 0, exp_rd = 0, exp_sound = 0, exp_valid = 0;
  int nxt_addr, nxt_rd, nxt_sound, nxt_valid;
  bit h1_vld = 0, h2_vld = 0;
  int h1_k, h1_a, h2_k, h2_a;
  int m_acc = 0;
  bit m_armed = 0;
  int vol [5];
  int en [5];
  int smp, contrib;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous wave RAM: data one clock after the read strobe.
  always @(posedge clk) if (wif.ram_rd) wif.ram_rdata <= ram_mem[wif.ram_address];

  always @(posedge reset) rst_seen = 1;

  always @(negedge clk) begin
    if (rst_seen || reset) begin
      rst_seen = 0;
      exp_addr = 0; exp_rd = 0; exp_sound = 0; exp_valid = 0;
      h1_vld = 0; h2_vld = 0; m_acc = 0; m_armed = 0;
    end
    check("ram_rd", int'(wif.ram_rd), exp_rd);
    check("ram_address", int'(wif.ram_address), exp_addr);
    check("sound_valid", int'(wif.sound_valid), exp_valid);
    check("sound_out", $signed(wif.sound_out), exp_sound);
    if (wif.sound_valid) begin
      pulse_cnt++;
      last_sound = $signed(wif.sound_out);
      valid_cyc = cyc;
    end

    nxt_rd = 0; nxt_addr = exp_addr; nxt_valid = 0; nxt_sound = exp_sound;
    if (!reset) begin
      vol[0] = wif.reg_volume_a; vol[1] = wif.reg_volume_b; vol[2] = wif.reg_volume_c;
      vol[3] = wif.reg_volume_d; vol[4] = wif.reg_volume_e;
      for (int i = 0; i < 5; i++) en[i] = wif.reg_enable[i];
      if (wif.active < 5) begin
        nxt_rd = 1;
        nxt_addr = int'(wif.active) * 128 + int'(wif.wave_address);
      end
      if (h2_vld) begin
        smp = $signed(ram_mem[h2_k * 128 + h2_a]);
        contrib = (en[h2_k] != 0) ? smp * vol[h2_k] : 0;
        if (h2_k == 0) begin
          m_acc = contrib;
          m_armed = 1;
        end else begin
          m_acc = m_acc + contrib;
        end
        if (h2_k == 4 && m_armed) begin
          nxt_sound = m_acc;
          nxt_valid = 1;
        end
      end
      h2_vld = h1_vld; h2_k = h1_k; h2_a = h1_a;
      h1_vld = (wif.active < 5); h1_k = int'(wif.active); h1_a = int'(wif.wave_address);
    end else begin
      h1_vld = 0; h2_vld = 0;
    end
    exp_addr = nxt_addr; exp_rd = nxt_rd; exp_sound = nxt_sound; exp_valid = nxt_valid;
  end

  task automatic drive(input int k, input int addr);
    wif.active = 3'(k);
    wif.wave_address = 7'(addr);
    if (k == 4) a4_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5, 0);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) ram_mem[i] = v;
  endtask

  task automatic set_vol(input int a, input int b, input int c, input int d, input int e);
    wif.reg_volume_a = 4'(a); wif.reg_volume_b = 4'(b); wif.reg_volume_c = 4'(c);
    wif.reg_volume_d = 4'(d); wif.reg_volume_e = 4'(e);
  endtask

  task automatic run_round(input int addr, input bit chk_addr, input bit c_change);
    for (int k = 0; k < 6; k++) begin
      if (c_change && k == 3) wif.reg_volume_c = 4'd0;
      drive(k, addr);
      if (chk_addr) begin
        if (k < 5) begin
          check("round_addr", int'(wif.ram_address), k * 128 + addr);
          check("round_rd", int'(wif.ram_rd), 1);
        end else begin
          check("idle_addr_hold", int'(wif.ram_address), 4 * 128 + addr);
          check("idle_rd", int'(wif.ram_rd), 0);
        end
      end
    end
    idle(3);
  endtask

  int base;

  initial begin
    reset = 1'b1;
    wif.active = 3'd5;
    wif.wave_address = '0;
    wif.reg_enable = 5'h1f;
    wif.ram_rdata = '0;
    set_vol(15, 15, 15, 15, 15);
    fill(8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd", int'(wif.ram_rd), 0);
    check("reset_addr", int'(wif.ram_address), 0);
    check("reset_sound", int'(wif.sound_out), 0);
    check("reset_valid", int'(wif.sound_valid), 0);
    reset = 1'b0;
    idle(2);

    fill(8'd127);
    base = pulse_cnt;
    run_round(5, 0, 0);
    check("max_pos_sound", last_sound, 9525);
    check("max_pos_pulses", pulse_cnt - base, 1);
    check("latency", valid_cyc - a4_cyc, 3);

    fill(8'h80);
    base = pulse_cnt;
    run_round(9, 0, 0);
    check("max_neg_sound", last_sound, -9600);
    check("max_neg_pulses", pulse_cnt - base, 1);

    fill(8'd1);
    set_vol(1, 2, 3, 4, 5);
    run_round(100, 0, 0);
    check("vol_ramp_sound", last_sound, 15);

    fill(8'd10);
    set_vol(15, 15, 15, 15, 15);
    wif.reg_enable = 5'b00100;
    run_round(8'h15, 1, 0);
    check("only_c_sound", last_sound, 150);

    wif.reg_enable = 5'h1f;
    set_vol(8, 8, 8, 8, 8);
    run_round(3, 0, 1);
    check("late_vol_c_sound", last_sound, 320);
    wif.reg_volume_c = 4'd8;

    drive(0, 7);
    drive(1, 7);
    wif.active = 3'd2;
    #1 reset = 1'b1;
    #1;
    check("async_rst_rd", int'(wif.ram_rd), 0);
    check("async_rst_addr", int'(wif.ram_address), 0);
    check("async_rst_sound", int'(wif.sound_out), 0);
    check("async_rst_valid", int'(wif.sound_valid), 0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    base = pulse_cnt;
    drive(3, 7);
    drive(4, 7);
    idle(4);
    check("partial_no_pulse", pulse_cnt - base, 0);
    check("partial_sound_zero", int'(wif.sound_out), 0);
    run_round(7, 0, 0);
    check("post_rst_pulses", pulse_cnt - base, 1);
    check("post_rst_sound", last_sound, 400);

    base = pulse_cnt;
    for (int i = 0; i < 20; i++) drive(6, 33);
    check("hold6_rd", int'(wif.ram_rd), 0);
    check("hold6_pulses", pulse_cnt - base, 0);
    check("hold6_sound", $signed(wif.sound_out), 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
